// File: rtl/du_tx_arbiter_if.sv
// Request/byte bus between the debug sub-block UART channels and the TX arbiter.
// master = requesting side plus TX FIFO status, slave = the arbiter.
interface du_tx_arbiter_if #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned NB_UART_DATA = 8
);
  logic [N_CH-1:0]              i_req;
  logic [N_CH-1:0]              i_last;
  logic [N_CH*NB_UART_DATA-1:0] i_data;
  logic                         i_tx_full;
  logic [N_CH-1:0]              o_ack;
  logic [N_CH-1:0]              o_grant;
  logic                         o_wr;
  logic [NB_UART_DATA-1:0]      o_wdata;
  logic                         o_tx_start;
  logic                         o_abort;
  logic                         o_busy;

  modport master (
    output i_req, i_last, i_data, i_tx_full,
    input  o_ack, o_grant, o_wr, o_wdata, o_tx_start, o_abort, o_busy
  );

  modport slave (
    input  i_req, i_last, i_data, i_tx_full,
    output o_ack, o_grant, o_wr, o_wdata, o_tx_start, o_abort, o_busy
  );
endinterface

// File: rtl/du_tx_arbiter.sv
// Packet-granular N-channel UART TX arbiter: round-robin or fixed priority,
// FIFO back-pressure, end-of-packet start pulse and idle-grant watchdog.
module du_tx_arbiter #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned NB_UART_DATA = 8,
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic           clk,
  input  logic           i_rst,
  du_tx_arbiter_if.slave bus_if
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, START} state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [N_CH-1:0]         grant_q, grant_d;
  logic                    wr_q, wr_d;
  logic [NB_UART_DATA-1:0] wdata_q, wdata_d;
  logic                    tx_start_q, tx_start_d;
  logic                    abort_q, abort_d;
  logic                    busy_q, busy_d;

  logic [N_CH-1:0]         ack_c;
  logic [PTR_W-1:0]        win_idx, hi_idx, lo_idx, nxt_ptr;
  logic                    hi_found;
  logic                    own_req, own_last, own_ack;
  logic [NB_UART_DATA-1:0] own_data;

  // Winner: lowest requester at/after the rr pointer, else lowest overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus_if.i_req[i]) begin
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
    win_idx = ((PRIO_MODE == 0) && hi_found) ? hi_idx : lo_idx;
  end

  // Current owner's request, last flag and byte
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (PTR_W'(i) == owner_q) begin
        own_req  = bus_if.i_req[i];
        own_last = bus_if.i_last[i];
        own_data = bus_if.i_data[i*NB_UART_DATA +: NB_UART_DATA];
      end
    end
  end

  assign nxt_ptr = (owner_q == PTR_W'(N_CH - 1)) ? '0 : owner_q + PTR_W'(1);
  assign own_ack = (state_q == XFER) && own_req && !bus_if.i_tx_full;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wd_d       = wd_q;
    grant_d    = grant_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    tx_start_d = 1'b0;
    abort_d    = 1'b0;
    ack_c      = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus_if.i_req) begin
          state_d = XFER;
          owner_d = win_idx;
          wd_d    = '0;
          for (int i = 0; i < N_CH; i++) begin
            grant_d[i] = (PTR_W'(i) == win_idx);
          end
        end
      end
      XFER: begin
        for (int i = 0; i < N_CH; i++) begin
          ack_c[i] = own_ack && (PTR_W'(i) == owner_q);
        end
        if (own_ack) begin
          wr_d    = 1'b1;
          wdata_d = own_data;
          wd_d    = '0;
          if (own_last) begin
            state_d = START;
          end
        end else if ((TIMEOUT > 0) && (wd_q == WD_W'(TIMEOUT))) begin
          // Owner went silent too long: revoke without a start pulse
          abort_d = 1'b1;
          grant_d = '0;
          ptr_d   = nxt_ptr;
          wd_d    = '0;
          state_d = IDLE;
        end else if (!own_req && (TIMEOUT > 0)) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      START: begin
        tx_start_d = 1'b1;
        grant_d    = '0;
        ptr_d      = nxt_ptr;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      wd_q       <= '0;
      grant_q    <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      tx_start_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      tx_start_q <= tx_start_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_if.o_ack      = ack_c;
  assign bus_if.o_grant    = grant_q;
  assign bus_if.o_wr       = wr_q;
  assign bus_if.o_wdata    = wdata_q;
  assign bus_if.o_tx_start = tx_start_q;
  assign bus_if.o_abort    = abort_q;
  assign bus_if.o_busy     = busy_q;

endmodule
